// File: rtl/seg7_pkg.sv
// Character codes and glyph table shared by the scan controller and its decoder.
// Segment bits are {G,F,E,D,C,B,A}; the decimal point is added by the decoder.
package seg7_pkg;

  localparam logic [4:0] CODE_ZERO  = 5'd0;
  localparam logic [4:0] CODE_HEX_A = 5'd10;
  localparam logic [4:0] CODE_HEX_F = 5'd15;
  localparam logic [4:0] CODE_T     = 5'd16;
  localparam logic [4:0] CODE_DASH  = 5'd17;
  localparam logic [4:0] CODE_BLANK = 5'd18;

  function automatic logic [6:0] seg7_glyph(input logic [4:0] code);
    logic [6:0] g;
    case (code)
      5'd0:    g = 7'h3F;
      5'd1:    g = 7'h06;
      5'd2:    g = 7'h5B;
      5'd3:    g = 7'h4F;
      5'd4:    g = 7'h66;
      5'd5:    g = 7'h6D;
      5'd6:    g = 7'h7D;
      5'd7:    g = 7'h07;
      5'd8:    g = 7'h7F;
      5'd9:    g = 7'h6F;
      5'd10:   g = 7'h77;
      5'd11:   g = 7'h7C;
      5'd12:   g = 7'h39;
      5'd13:   g = 7'h5E;
      5'd14:   g = 7'h79;
      5'd15:   g = 7'h71;
      5'd16:   g = 7'h78;
      5'd17:   g = 7'h40;
      default: g = 7'h00;
    endcase
    return g;
  endfunction

  // Codes 18..31 all render dark, so they count as blank for zero suppression.
  function automatic logic is_zero_or_blank(input logic [4:0] code);
    return (code == CODE_ZERO) || (code >= CODE_BLANK);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational character decoder: 5-bit code plus decimal point to {DP,G..A}.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [4:0] code_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  assign seg_o = {dp_i, seg7_glyph(code_i)};

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scanner: digit buffer, slot prescaler with dead time,
// blink and upper-group leading-zero blanking, two segment buses.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000,
  parameter int DEAD_CYC   = 2,
  parameter int BLINK_DIV  = 250,
  localparam int AW        = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  lzb,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [4:0]            wr_code,
  input  logic                  wr_dp,
  input  logic                  wr_blink,
  output logic [7:0]            seg0,
  output logic [7:0]            seg1,
  output logic [NUM_DIGITS-1:0] dig_sel
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] DEAD_LEN   = PW'(DEAD_CYC);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [AW-1:0] IDX_LAST   = AW'(NUM_DIGITS - 1);
  localparam logic [AW-1:0] IDX_HALF   = AW'(NUM_DIGITS / 2);
  localparam logic [AW:0]   DIGITS_W   = (AW + 1)'(NUM_DIGITS);

  logic [PW-1:0]         presc_q, presc_d;
  logic [AW-1:0]         scan_q, scan_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic                  phase_q, phase_d;

  // Write buffer, and the copy actually displayed, refreshed at slot boundaries
  // so a write never changes a digit partway through its slot.
  logic [4:0]            code_q     [NUM_DIGITS];
  logic [4:0]            shd_code_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] dp_q, attr_q, shd_dp_q, shd_attr_q;

  logic [7:0]            seg0_d, seg1_d;
  logic [NUM_DIGITS-1:0] dig_sel_d;
  logic [NUM_DIGITS-1:0] higher_ok;
  logic                  run_ok;
  logic                  slot_end, wr_ok, suppress;
  logic [4:0]            cur_code, dec_code;
  logic [7:0]            dec_seg;

  assign slot_end = en && (presc_q == PRESC_LAST);
  assign wr_ok    = wr_en && ({1'b0, wr_addr} < DIGITS_W);

  // higher_ok[i]: every digit above i shows 0 or blank.
  always_comb begin
    run_ok    = 1'b1;
    higher_ok = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      higher_ok[i] = run_ok;
      run_ok       = run_ok & is_zero_or_blank(shd_code_q[i]);
    end
  end

  assign cur_code = shd_code_q[scan_q];
  assign suppress = lzb && (scan_q > IDX_HALF) && (cur_code == CODE_ZERO)
                    && higher_ok[scan_q];
  assign dec_code = suppress ? CODE_BLANK : cur_code;

  seg7_decode u_decode (
    .code_i (dec_code),
    .dp_i   (shd_dp_q[scan_q]),
    .seg_o  (dec_seg)
  );

  always_comb begin
    presc_d = presc_q;
    scan_d  = scan_q;
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (en) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        scan_d  = (scan_q == IDX_LAST) ? '0 : scan_q + 1'b1;
        if (bcnt_q == BLINK_LAST) begin
          bcnt_d  = '0;
          phase_d = ~phase_q;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_comb begin
    seg0_d    = '0;
    seg1_d    = '0;
    dig_sel_d = '0;
    if (en && (presc_q >= DEAD_LEN)) begin
      dig_sel_d[scan_q] = 1'b1;
      if (phase_q || !shd_attr_q[scan_q]) begin
        if (scan_q < IDX_HALF) seg0_d = dec_seg;
        else                   seg1_d = dec_seg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      scan_q  <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b1;
      seg0    <= '0;
      seg1    <= '0;
      dig_sel <= '0;
    end else begin
      presc_q <= presc_d;
      scan_q  <= scan_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      seg0    <= seg0_d;
      seg1    <= seg1_d;
      dig_sel <= dig_sel_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        code_q[i]     <= CODE_BLANK;
        shd_code_q[i] <= CODE_BLANK;
      end
      dp_q       <= '0;
      attr_q     <= '0;
      shd_dp_q   <= '0;
      shd_attr_q <= '0;
    end else begin
      if (slot_end) begin
        shd_code_q <= code_q;
        shd_dp_q   <= dp_q;
        shd_attr_q <= attr_q;
      end
      if (clr) begin
        for (int i = 0; i < NUM_DIGITS; i++) code_q[i] <= CODE_BLANK;
        dp_q   <= '0;
        attr_q <= '0;
      end else if (wr_ok) begin
        code_q[wr_addr] <= wr_code;
        dp_q[wr_addr]   <= wr_dp;
        attr_q[wr_addr] <= wr_blink;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench: arithmetic reference model checked every clock, plus a
// decode vector table and hand sequences for blink, blanking, clear and reset.
module tb_seg7_scan_ctrl;

  localparam int N  = 8;
  localparam int SD = 4;
  localparam int DC = 1;
  localparam int BD = 2;

  logic       clk = 1'b0;
  logic       rst_n, en, clr, lzb, wr_en, wr_dp, wr_blink;
  logic [2:0] wr_addr;
  logic [4:0] wr_code;
  logic [7:0] seg0, seg1, dig_sel;
  logic [7:0] seg0_b, seg1_b;
  logic [5:0] dig_sel_b;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(SD), .DEAD_CYC(DC), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .lzb(lzb), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_code(wr_code), .wr_dp(wr_dp), .wr_blink(wr_blink),
    .seg0(seg0), .seg1(seg1), .dig_sel(dig_sel)
  );

  seg7_scan_ctrl #(.NUM_DIGITS(6), .SCAN_DIV(SD), .DEAD_CYC(DC), .BLINK_DIV(BD)) dut6 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .lzb(lzb), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_code(wr_code), .wr_dp(wr_dp), .wr_blink(wr_blink),
    .seg0(seg0_b), .seg1(seg1_b), .dig_sel(dig_sel_b)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  // Reference model: t = enabled clocks since reset; everything else follows from it.
  int         t;
  logic [4:0] m_code [N];
  logic [4:0] m_scode[N];
  logic       m_dp [N], m_attr [N], m_sdp [N], m_sattr [N];

  logic [7:0] cap0 [N], cap1 [N];
  logic [7:0] seen;
  logic [7:0] capb0 [6], capb1 [6];
  logic [5:0] seenb;

  typedef struct {
    logic [4:0] code;
    logic       dp;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [12];

  function automatic logic [6:0] glyph(input logic [4:0] c);
    case (c)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;  10: return 7'h77; 11: return 7'h7C;
      12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; 15: return 7'h71;
      16: return 7'h78; 17: return 7'h40;
      default: return 7'h00;
    endcase
  endfunction

  function automatic void model_reset();
    t = 0;
    for (int i = 0; i < N; i++) begin
      m_code[i] = 5'd18; m_scode[i] = 5'd18;
      m_dp[i] = 0; m_attr[i] = 0; m_sdp[i] = 0; m_sattr[i] = 0;
    end
  endfunction

  function automatic void model_out(output logic [7:0] e0, output logic [7:0] e1,
                                    output logic [7:0] eds);
    int presc, slots, idx;
    logic phase, sup;
    logic [7:0] s;
    e0 = 0; e1 = 0; eds = 0;
    presc = t % SD;
    slots = t / SD;
    idx   = slots % N;
    phase = ((slots / BD) % 2) == 0;
    if (rst_n && en && presc >= DC) begin
      eds = 8'b1 << idx;
      sup = lzb && (idx > N / 2) && (m_scode[idx] == 0);
      for (int j = idx + 1; j < N; j++)
        if (!(m_scode[j] == 0 || m_scode[j] >= 18)) sup = 0;
      s = {m_sdp[idx], sup ? 7'h00 : glyph(m_scode[idx])};
      if (!phase && m_sattr[idx]) s = 0;
      if (idx < N / 2) e0 = s;
      else             e1 = s;
    end
  endfunction

  function automatic void model_update();
    if (!rst_n) begin
      model_reset();
    end else begin
      if (en) begin
        if (t % SD == SD - 1)
          for (int i = 0; i < N; i++) begin
            m_scode[i] = m_code[i]; m_sdp[i] = m_dp[i]; m_sattr[i] = m_attr[i];
          end
        t++;
      end
      if (clr) begin
        for (int i = 0; i < N; i++) begin
          m_code[i] = 5'd18; m_dp[i] = 0; m_attr[i] = 0;
        end
      end else if (wr_en && int'(wr_addr) < N) begin
        m_code[wr_addr] = wr_code; m_dp[wr_addr] = wr_dp; m_attr[wr_addr] = wr_blink;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_caps();
    for (int k = 0; k < N; k++) begin cap0[k] = 0; cap1[k] = 0; end
    for (int k = 0; k < 6; k++) begin capb0[k] = 0; capb1[k] = 0; end
    seen = 0; seenb = 0;
  endtask

  task automatic step();
    logic [7:0] e0, e1, eds;
    model_out(e0, e1, eds);
    @(posedge clk); #1;
    cyc++;
    chk("model", {8'h0, seg0, seg1, dig_sel}, {8'h0, e0, e1, eds});
    model_update();
    for (int k = 0; k < N; k++)
      if (dig_sel == (8'b1 << k)) begin cap0[k] = seg0; cap1[k] = seg1; seen[k] = 1'b1; end
    for (int k = 0; k < 6; k++)
      if (dig_sel_b == (6'b1 << k)) begin capb0[k] = seg0_b; capb1[k] = seg1_b; seenb[k] = 1'b1; end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic write(input int a, input int c, input logic d, input logic b);
    wr_addr = 3'(a); wr_code = 5'(c); wr_dp = d; wr_blink = b; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1; step(); clr = 1'b0;
  endtask

  task automatic settle_and_capture(input int n);
    run(32); clear_caps(); run(n);
  endtask

  logic [7:0] seq [40];
  logic [7:0] exp_seq [6];
  logic       found;

  initial begin
    vecs[0]  = '{5'd3,  1'b1, 8'hCF};
    vecs[1]  = '{5'd10, 1'b0, 8'h77};
    vecs[2]  = '{5'd8,  1'b0, 8'h7F};
    vecs[3]  = '{5'd0,  1'b0, 8'h3F};
    vecs[4]  = '{5'd17, 1'b1, 8'hC0};
    vecs[5]  = '{5'd16, 1'b0, 8'h78};
    vecs[6]  = '{5'd11, 1'b0, 8'h7C};
    vecs[7]  = '{5'd13, 1'b0, 8'h5E};
    vecs[8]  = '{5'd7,  1'b0, 8'h07};
    vecs[9]  = '{5'd25, 1'b0, 8'h00};
    vecs[10] = '{5'd18, 1'b1, 8'h80};
    vecs[11] = '{5'd2,  1'b1, 8'hDB};
    exp_seq[0] = 8'h00; exp_seq[1] = 8'h01; exp_seq[2] = 8'h01;
    exp_seq[3] = 8'h01; exp_seq[4] = 8'h00; exp_seq[5] = 8'h02;

    rst_n = 0; en = 0; clr = 0; lzb = 0; wr_en = 0;
    wr_addr = 0; wr_code = 0; wr_dp = 0; wr_blink = 0;
    model_reset();
    clear_caps();
    run(3);
    chk("reset_outputs", {8'h0, seg0, seg1, dig_sel}, 32'h0);

    // Scan order and dead period from a fresh reset.
    rst_n = 1; en = 1;
    for (int i = 0; i < 40; i++) begin step(); seq[i] = dig_sel; end
    for (int i = 0; i < 6; i++) begin
      chk("scan_seq", {24'h0, seq[i]}, {24'h0, exp_seq[i]});
      chk("scan_period", {24'h0, seq[i + 32]}, {24'h0, exp_seq[i]});
    end

    // Decode vectors on both the lower group (digit 0) and upper group (digit 7).
    for (int v = 0; v < 12; v++) begin
      write(0, vecs[v].code, vecs[v].dp, 1'b0);
      write(7, vecs[v].code, vecs[v].dp, 1'b0);
      settle_and_capture(32);
      chk("tbl_lo", {24'h0, cap0[0]}, {24'h0, vecs[v].exp});
      chk("tbl_hi", {24'h0, cap1[7]}, {24'h0, vecs[v].exp});
      chk("tbl_lo_other_bus", {24'h0, cap1[0]}, 32'h0);
    end

    // Blink: with 8 digits and 2-slot half periods, digit 5 always lands in
    // phase 1 and digit 6 always in phase 0.
    do_clr();
    write(5, 8, 1'b0, 1'b1);
    write(6, 8, 1'b0, 1'b1);
    settle_and_capture(64);
    chk("blink_shown", {24'h0, cap1[5]}, 32'h7F);
    chk("blink_dark", {24'h0, cap1[6]}, 32'h0);
    chk("blink_digsel", {31'h0, seen[6]}, 32'h1);

    // Leading-zero blanking in the upper group.
    do_clr();
    write(7, 0, 1'b0, 1'b0);
    write(6, 0, 1'b0, 1'b0);
    write(5, 4, 1'b0, 1'b0);
    write(4, 0, 1'b0, 1'b0);
    lzb = 1;
    settle_and_capture(32);
    chk("lzb_d7", {24'h0, cap1[7]}, 32'h0);
    chk("lzb_d6", {24'h0, cap1[6]}, 32'h0);
    chk("lzb_d5", {24'h0, cap1[5]}, 32'h66);
    chk("lzb_d4", {24'h0, cap1[4]}, 32'h3F);
    lzb = 0;

    // Clear wins over a same-cycle write.
    write(2, 8, 1'b1, 1'b0);
    run(8);
    clr = 1; wr_en = 1; wr_addr = 3'd2; wr_code = 5'd1; wr_dp = 0; wr_blink = 0;
    step();
    clr = 0; wr_en = 0;
    settle_and_capture(32);
    chk("clr_prio", {24'h0, cap0[2]}, 32'h0);
    chk("clr_prio_seen", {31'h0, seen[2]}, 32'h1);

    // Six-digit instance: addresses 6 and 7 must be ignored.
    rst_n = 0; step(); rst_n = 1;
    write(6, 5, 1'b1, 1'b0);
    write(7, 5, 1'b0, 1'b0);
    write(5, 2, 1'b0, 1'b0);
    settle_and_capture(48);
    chk("n6_d5", {24'h0, capb1[5]}, 32'h5B);
    for (int k = 0; k < 5; k++)
      chk("n6_blank", {24'h0, capb0[k] | capb1[k]}, 32'h0);
    chk("n6_scan", {26'h0, seenb}, 32'h3F);

    // Reset in the middle of slot 3.
    found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      step();
      if (dig_sel == 8'h08) found = 1;
    end
    chk("find_slot3", {31'h0, found}, 32'h1);
    rst_n = 0; step();
    chk("rst_mid", {8'h0, seg0, seg1, dig_sel}, 32'h0);
    rst_n = 1; step();
    chk("rst_dead", {24'h0, dig_sel}, 32'h0);
    step();
    chk("rst_restart", {24'h0, dig_sel}, 32'h01);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n    = ($urandom % 400) != 0;
      en       = ($urandom % 8) != 0;
      clr      = ($urandom % 80) == 0;
      if ($urandom % 50 == 0) lzb = ~lzb;
      wr_en    = ($urandom % 4) == 0;
      wr_addr  = 3'($urandom);
      wr_code  = ($urandom % 3 == 0) ? 5'd0 : 5'($urandom);
      wr_dp    = 1'($urandom);
      wr_blink = ($urandom % 4) == 0;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
